// File: rtl/bip_pkg.sv
// Shared definitions for the basic accumulator processor control unit:
// opcodes, ALU op codes, accumulator mux selects, FSM states and the decode bundle.
package bip_pkg;

    localparam int BITS_ADDRESS = 11;
    localparam int BITS_OPCODE  = 5;
    localparam int INSTR_W      = BITS_OPCODE + BITS_ADDRESS;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    localparam logic [5:0] OP_NONE = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic       needs_mem;
        logic       writes_acc;
        logic       writes_ram;
        logic [5:0] alu_op;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       is_halt;
        logic       is_illegal;
    } decode_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// Combinational opcode decoder: maps the latched opcode to the datapath
// control bundle used by the sequencing FSM in EXEC and WB.
module bip_instr_decoder
    import bip_pkg::*;
#(
    parameter int bits_opcode = BITS_OPCODE
) (
    input  logic [bits_opcode-1:0] opcode,
    output decode_t                dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OPC_HLT:  dec.is_halt = 1'b1;
            OPC_STO:  dec.writes_ram = 1'b1;
            OPC_LDI: begin
                dec.writes_acc = 1'b1;
                dec.sel_a      = SEL_A_IMM;
            end
            OPC_ADDI, OPC_SUBI: begin
                dec.writes_acc = 1'b1;
                dec.sel_b      = 1'b1;
                dec.sel_a      = SEL_A_ALU;
                dec.alu_op     = (opcode == OPC_ADDI) ? OP_ADD : OP_SUB;
            end
            OPC_LD: begin
                dec.needs_mem  = 1'b1;
                dec.writes_acc = 1'b1;
                dec.sel_a      = SEL_A_RAM;
            end
            OPC_ADD, OPC_SUB: begin
                dec.needs_mem  = 1'b1;
                dec.writes_acc = 1'b1;
                dec.sel_b      = 1'b0;
                dec.sel_a      = SEL_A_ALU;
                dec.alu_op     = (opcode == OPC_ADD) ? OP_ADD : OP_SUB;
            end
            default:  dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// Fetch/decode/execute/write-back sequencer for the accumulator processor.
// Optional BIP_CYCLE_COUNT_EN adds cycle_count and instr_count performance counters.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int bits_address = BITS_ADDRESS,
    parameter int bits_opcode  = BITS_OPCODE
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [bits_opcode+bits_address-1:0] instr_data,
    output logic                              WrPC,
    output logic [bits_address-1:0]           operand,
    output logic [1:0]                        SelA,
    output logic                              SelB,
    output logic                              WrAcc,
    output logic [5:0]                        Op,
    output logic                              WrRam,
    output logic                              RdRam,
    output logic                              halted,
    output logic                              illegal_op,
    output logic [2:0]                        dbg_state
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [31:0]                       cycle_count,
    output logic [15:0]                       instr_count
`endif
);

    state_t                               state, state_nxt;
    logic [bits_opcode+bits_address-1:0]  instr_reg;
    logic                                 illegal_q;
    decode_t                              dec;

    bip_instr_decoder #(.bits_opcode(bits_opcode)) u_decoder (
        .opcode (instr_reg[bits_opcode+bits_address-1 -: bits_opcode]),
        .dec    (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            instr_reg <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // The ROM word is stable during DECODE, one cycle after FETCH.
            if (state == DECODE)
                instr_reg <= instr_data;
            if (state == EXEC && dec.is_illegal)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        WrPC      = 1'b0;
        SelA      = SEL_A_RAM;
        SelB      = 1'b0;
        WrAcc     = 1'b0;
        Op        = OP_NONE;
        WrRam     = 1'b0;
        RdRam     = 1'b0;
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (dec.is_halt) begin
                    state_nxt = HALT;
                end else if (dec.needs_mem) begin
                    RdRam     = 1'b1;
                    state_nxt = WB;
                end else begin
                    WrRam     = dec.writes_ram;
                    WrAcc     = dec.writes_acc;
                    SelA      = dec.sel_a;
                    SelB      = dec.sel_b;
                    Op        = dec.alu_op;
                    WrPC      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            // RAM data returned for the read issued in EXEC is consumed here.
            WB: begin
                SelA      = dec.sel_a;
                SelB      = dec.sel_b;
                Op        = dec.alu_op;
                WrAcc     = 1'b1;
                WrPC      = 1'b1;
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    assign operand    = instr_reg[bits_address-1:0];
    assign halted     = (state == HALT);
    // Visible already in the offending EXEC cycle, then held by the sticky register.
    assign illegal_op = illegal_q | ((state == EXEC) && dec.is_illegal);
    assign dbg_state  = state;

`ifdef BIP_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (state != HALT) begin
            if (cycle_count != '1)
                cycle_count <= cycle_count + 32'd1;
            if (WrPC)
                instr_count <= instr_count + 16'd1;
        end
    end
`endif

endmodule
